// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with single-word fills from the memory i-port.
// Optional same-cycle forwarding of fill data is enabled by defining ICACHE_BYPASS_EN.
module icache_direct_mapped #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dp_imemREN,
  input  logic [31:0] dp_imemaddr,
  output logic        dp_ihit,
  output logic [31:0] dp_imemload,
  output logic        mem_iREN,
  output logic [31:0] mem_iaddr,
  input  logic        mem_iwait,
  input  logic [31:0] mem_iload
);

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fill_addr_q, fill_addr_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              array_hit;
  logic              fill_done;

  assign req_idx   = dp_imemaddr[IDX_W+1:2];
  assign req_tag   = dp_imemaddr[31:IDX_W+2];
  assign fill_idx  = fill_addr_q[IDX_W+1:2];
  assign fill_tag  = fill_addr_q[31:IDX_W+2];
  assign array_hit = dp_imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign fill_done = (state_q == FILL) & ~mem_iwait;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    valid_d     = valid_q;
    dp_ihit     = 1'b0;
    dp_imemload = '0;
    mem_iREN    = 1'b0;
    mem_iaddr   = '0;

    case (state_q)
      IDLE: begin
        if (array_hit) begin
          dp_ihit     = 1'b1;
          dp_imemload = data_q[req_idx];
        end else if (dp_imemREN) begin
          state_d     = FILL;
          fill_addr_d = dp_imemaddr;
        end
      end
      FILL: begin
        // The fill always finishes into the latched frame; the fetch side may wander meanwhile.
        mem_iREN  = 1'b1;
        mem_iaddr = fill_addr_q;
        if (!mem_iwait) begin
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
`ifdef ICACHE_BYPASS_EN
          if (dp_imemREN && (dp_imemaddr == fill_addr_q)) begin
            dp_ihit     = 1'b1;
            dp_imemload = mem_iload;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone decide whether a frame is usable.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_iload;
    end
  end

endmodule
